dcpu16_mbus_arb: RTL and testbench

//   Two-master / one-slave arbiter for the DCPU16 memory port. Shares the single

---
 rtl/dcpu16_defs.sv | 21 ++
 rtl/dcpu16_mbus_tmo.sv | 27 ++
 rtl/dcpu16_mbus_arb.sv | 124 ++++++++++++
 tb/tb_dcpu16_mbus_arb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dcpu16_defs.sv
// Shared DCPU16 memory-bus definitions: arbiter state encodings, grant
// constants, the error read-data word and the arbitration helper.
package dcpu16_defs;

   typedef enum logic [1:0] {
      MBUS_IDLE    = 2'd0,
      MBUS_BUSY_FS = 2'd1,
      MBUS_BUSY_AB = 2'd2
   } mbus_state_e;

   localparam logic [1:0]  GNT_FS          = 2'b01;
   localparam logic [1:0]  GNT_AB          = 2'b10;
   localparam logic [15:0] DCPU16_ERR_DATA = 16'hFFFF;

   // AB wins when FS is idle, or under round-robin when FS was granted last.
   function automatic logic mbus_pick_ab(input logic fs_req, input logic ab_req,
                                         input logic last_ab, input logic rr_en);
      return ab_req && (!fs_req || (rr_en && !last_ab));
   endfunction

endpackage

// File: rtl/dcpu16_mbus_tmo.sv
// Saturating wait-cycle counter for the memory-bus arbiter; expired_o is
// high while the count is all-ones.
module dcpu16_mbus_tmo #(
   parameter int TMO_W = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   logic [TMO_W-1:0] cnt_q;

   assign expired_o = &cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/dcpu16_mbus_arb.sv
// Two-master (FS, AB) to one-slave memory-bus arbiter with registered slave
// requests and timeout abort. Define DCPU16_MBUS_RR_EN for round-robin.
module dcpu16_mbus_arb
   import dcpu16_defs::*;
#(
   parameter int AW    = 16,
   parameter int DW    = 16,
   parameter int TMO_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] fs_adr,
   input  logic          fs_stb,
   input  logic          fs_wre,
   input  logic [DW-1:0] fs_dto,
   output logic [DW-1:0] fs_dti,
   output logic          fs_ack,
   input  logic [AW-1:0] ab_adr,
   input  logic          ab_stb,
   input  logic          ab_wre,
   input  logic [DW-1:0] ab_dto,
   output logic [DW-1:0] ab_dti,
   output logic          ab_ack,
   output logic [AW-1:0] wb_adr,
   output logic          wb_stb,
   output logic          wb_wre,
   output logic [DW-1:0] wb_dto,
   input  logic [DW-1:0] wb_dti,
   input  logic          wb_ack,
   output logic [1:0]    gnt,
   output logic          bus_err
);

`ifdef DCPU16_MBUS_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   localparam logic [DW-1:0] ERR_D = (DW == 16) ? DW'(DCPU16_ERR_DATA) : {DW{1'b1}};

   mbus_state_e   state_q;
   logic [AW-1:0] wb_adr_q;
   logic [DW-1:0] wb_dto_q;
   logic          wb_stb_q, wb_wre_q, bus_err_q, last_ab_q;
   logic [1:0]    gnt_q;
   logic          busy, tmo_exp, done, win_ab;

   assign busy   = (state_q != MBUS_IDLE);
   assign done   = busy && (wb_ack || tmo_exp);
   assign win_ab = mbus_pick_ab(fs_stb, ab_stb, last_ab_q, RR_EN);

   dcpu16_mbus_tmo #(.TMO_W(TMO_W)) u_tmo (
      .clk_i     (clk),
      .rst_ni    (rst),
      .clr_i     (!busy || wb_ack || tmo_exp),
      .inc_i     (busy && !wb_ack),
      .expired_o (tmo_exp)
   );

   // Ack and read data go back combinationally to the granted master only.
   assign fs_ack = done && (state_q == MBUS_BUSY_FS);
   assign ab_ack = done && (state_q == MBUS_BUSY_AB);
   assign fs_dti = fs_ack ? (wb_ack ? wb_dti : ERR_D) : '0;
   assign ab_dti = ab_ack ? (wb_ack ? wb_dti : ERR_D) : '0;

   assign wb_adr  = wb_adr_q;
   assign wb_stb  = wb_stb_q;
   assign wb_wre  = wb_wre_q;
   assign wb_dto  = wb_dto_q;
   assign gnt     = gnt_q;
   assign bus_err = bus_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= MBUS_IDLE;
         wb_adr_q  <= '0;
         wb_dto_q  <= '0;
         wb_stb_q  <= 1'b0;
         wb_wre_q  <= 1'b0;
         gnt_q     <= 2'b00;
         bus_err_q <= 1'b0;
         last_ab_q <= 1'b0;
      end else begin
         bus_err_q <= 1'b0;
         case (state_q)
            MBUS_IDLE: begin
               if (fs_stb || ab_stb) begin
                  wb_stb_q  <= 1'b1;
                  last_ab_q <= win_ab;
                  if (win_ab) begin
                     state_q  <= MBUS_BUSY_AB;
                     gnt_q    <= GNT_AB;
                     wb_adr_q <= ab_adr;
                     wb_wre_q <= ab_wre;
                     wb_dto_q <= ab_dto;
                  end else begin
                     state_q  <= MBUS_BUSY_FS;
                     gnt_q    <= GNT_FS;
                     wb_adr_q <= fs_adr;
                     wb_wre_q <= fs_wre;
                     wb_dto_q <= fs_dto;
                  end
               end
            end
            MBUS_BUSY_FS, MBUS_BUSY_AB: begin
               // gnt doubles as the observable FSM state.
               if (wb_ack || tmo_exp) begin
                  state_q   <= MBUS_IDLE;
                  wb_stb_q  <= 1'b0;
                  gnt_q     <= 2'b00;
                  bus_err_q <= !wb_ack;
               end
            end
            default: begin
               state_q  <= MBUS_IDLE;
               wb_stb_q <= 1'b0;
               gnt_q    <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Directed self-checking bench for dcpu16_mbus_arb (default TMO_W=4).
module tb_dcpu16_mbus_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] fs_adr = '0, fs_dto = '0, ab_adr = '0, ab_dto = '0, wb_dti = '0;
   logic        fs_stb = 1'b0, fs_wre = 1'b0, ab_stb = 1'b0, ab_wre = 1'b0, wb_ack = 1'b0;
   logic [15:0] fs_dti, ab_dti, wb_adr, wb_dto;
   logic        fs_ack, ab_ack, wb_stb, wb_wre, bus_err;
   logic [1:0]  gnt;

   int n_vec = 0;
   int n_err = 0;

   dcpu16_mbus_arb dut (
      .clk(clk), .rst(rst),
      .fs_adr(fs_adr), .fs_stb(fs_stb), .fs_wre(fs_wre), .fs_dto(fs_dto),
      .fs_dti(fs_dti), .fs_ack(fs_ack),
      .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_wre(ab_wre), .ab_dto(ab_dto),
      .ab_dti(ab_dti), .ab_ack(ab_ack),
      .wb_adr(wb_adr), .wb_stb(wb_stb), .wb_wre(wb_wre), .wb_dto(wb_dto),
      .wb_dti(wb_dti), .wb_ack(wb_ack),
      .gnt(gnt), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   int          n_ack;
   logic [1:0]  exp_gnt;

   initial begin
      // Reset state
      #3;
      check_eq("rst_gnt", {30'd0, gnt}, 32'd0);
      check_eq("rst_wb_stb", {31'd0, wb_stb}, 32'd0);
      check_eq("rst_bus_err", {31'd0, bus_err}, 32'd0);
      check_eq("rst_acks", {30'd0, fs_ack, ab_ack}, 32'd0);
      cyc();
      rst = 1'b1;
      cyc();

      // 1. Async reset in the middle of an AB cycle
      ab_stb = 1'b1; ab_adr = 16'h0055;
      cyc(); #1;
      check_eq("t1_gnt_ab", {30'd0, gnt}, 32'd2);
      check_eq("t1_wb_stb", {31'd0, wb_stb}, 32'd1);
      rst = 1'b0; #1;
      check_eq("t1_async_gnt", {30'd0, gnt}, 32'd0);
      check_eq("t1_async_stb", {31'd0, wb_stb}, 32'd0);
      check_eq("t1_async_adr", {16'd0, wb_adr}, 32'd0);
      check_eq("t1_async_ack", {30'd0, fs_ack, ab_ack}, 32'd0);
      ab_stb = 1'b0;
      cyc();
      rst = 1'b1;
      cyc(); #1;
      check_eq("t1_idle_gnt", {30'd0, gnt}, 32'd0);
      check_eq("t1_idle_stb", {31'd0, wb_stb}, 32'd0);

      // 2. FS read, memory acks on the second busy cycle
      cyc();
      fs_stb = 1'b1; fs_adr = 16'h0010; fs_wre = 1'b0;
      cyc(); #1;
      check_eq("t2_gnt_fs", {30'd0, gnt}, 32'd1);
      check_eq("t2_wb_adr", {16'd0, wb_adr}, 32'h0010);
      check_eq("t2_wb_wre", {31'd0, wb_wre}, 32'd0);
      check_eq("t2_no_ack_yet", {31'd0, fs_ack}, 32'd0);
      cyc();
      wb_ack = 1'b1; wb_dti = 16'hBEEF; #1;
      check_eq("t2_fs_ack", {31'd0, fs_ack}, 32'd1);
      check_eq("t2_fs_dti", {16'd0, fs_dti}, 32'hBEEF);
      check_eq("t2_ab_quiet", {15'd0, ab_ack, ab_dti}, 32'd0);
      cyc();
      wb_ack = 1'b0; fs_stb = 1'b0; #1;
      check_eq("t2_back_idle", {31'd0, wb_stb}, 32'd0);
      check_eq("t2_ack_pulse", {31'd0, fs_ack}, 32'd0);

      // 4. AB write with an immediate memory ack
      ab_stb = 1'b1; ab_wre = 1'b1; ab_dto = 16'h1234; ab_adr = 16'h8000;
      cyc(); #1;
      check_eq("t4_gnt_ab", {30'd0, gnt}, 32'd2);
      check_eq("t4_wb_wre", {31'd0, wb_wre}, 32'd1);
      check_eq("t4_wb_dto", {16'd0, wb_dto}, 32'h1234);
      check_eq("t4_wb_adr", {16'd0, wb_adr}, 32'h8000);
      wb_ack = 1'b1; wb_dti = 16'h0000; #1;
      check_eq("t4_ab_ack", {31'd0, ab_ack}, 32'd1);
      check_eq("t4_fs_ack", {31'd0, fs_ack}, 32'd0);
      cyc();
      wb_ack = 1'b0; ab_stb = 1'b0; ab_wre = 1'b0;

      // 3. Contention with both strobes held; last grant so far was AB
      fs_stb = 1'b1; ab_stb = 1'b1; fs_adr = 16'h0100; ab_adr = 16'h0200;
      for (int i = 0; i < 4; i++) begin
`ifdef DCPU16_MBUS_RR_EN
         exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_gnt = 2'b01;
`endif
         cyc(); #1;
         check_eq($sformatf("t3_gnt_%0d", i), {30'd0, gnt}, {30'd0, exp_gnt});
         check_eq($sformatf("t3_adr_%0d", i), {16'd0, wb_adr},
                  (exp_gnt == 2'b01) ? 32'h0100 : 32'h0200);
         wb_ack = 1'b1; #1;
         check_eq($sformatf("t3_ack_%0d", i), {30'd0, ab_ack, fs_ack}, {30'd0, exp_gnt});
         cyc();
         wb_ack = 1'b0; #1;
         check_eq($sformatf("t3_gap_%0d", i), {30'd0, gnt}, 32'd0);
      end
      fs_stb = 1'b0;
      cyc(); #1;
      check_eq("t3_ab_after_fs", {30'd0, gnt}, 32'd2);
      wb_ack = 1'b1;
      cyc();
      wb_ack = 1'b0; ab_stb = 1'b0;

      // 5. Timeout: no memory ack at all
      fs_stb = 1'b1; fs_adr = 16'h0042;
      cyc();
      n_ack = 0;
      for (int k = 0; k < 15; k++) begin
         #1;
         if (fs_ack || bus_err) n_ack++;
         cyc();
      end
      check_eq("t5_quiet_wait", n_ack, 32'd0);
      #1;
      check_eq("t5_fs_ack", {31'd0, fs_ack}, 32'd1);
      check_eq("t5_fs_dti", {16'd0, fs_dti}, 32'hFFFF);
      check_eq("t5_err_not_yet", {31'd0, bus_err}, 32'd0);
      check_eq("t5_ab_quiet", {15'd0, ab_ack, ab_dti}, 32'd0);
      cyc();
      fs_stb = 1'b0; #1;
      check_eq("t5_bus_err", {31'd0, bus_err}, 32'd1);
      check_eq("t5_idle", {29'd0, wb_stb, gnt}, 32'd0);
      cyc(); #1;
      check_eq("t5_err_pulse", {31'd0, bus_err}, 32'd0);

      // Counter must restart from zero for the next cycle
      fs_stb = 1'b1;
      cyc(); #1;
      check_eq("t5_fresh_no_ack", {31'd0, fs_ack}, 32'd0);
      wb_ack = 1'b1; wb_dti = 16'h00A5; #1;
      check_eq("t5_fresh_dti", {16'd0, fs_dti}, 32'h00A5);
      cyc();
      wb_ack = 1'b0; fs_stb = 1'b0;
      cyc();

      // 6. Stray memory ack while idle
      wb_ack = 1'b1; wb_dti = 16'h5A5A; #1;
      check_eq("t6_no_acks", {30'd0, fs_ack, ab_ack}, 32'd0);
      check_eq("t6_no_dti", {fs_dti, ab_dti}, 32'd0);
      cyc();
      wb_ack = 1'b0; #1;
      check_eq("t6_still_idle", {29'd0, wb_stb, gnt}, 32'd0);
      check_eq("t6_no_err", {31'd0, bus_err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
